// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the fixed-latency data memory: independent LD and ST channels.
// Zero added latency: requests and responses are forwarded combinationally; only ownership is registered.
// Backpressure: memory ready passes to the granted port; a full owner FIFO withholds the grant.

// One channel: round-robin select with request lock, plus an owner FIFO for response routing.
module dmem_arb_chan #(
    parameter int PW    = 36,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      i_s_valid,
    output logic [1:0]      o_s_ready,
    input  logic [2*PW-1:0] i_s_pay,
    output logic            o_m_valid,
    input  logic            i_m_ready,
    output logic [PW-1:0]   o_m_pay,
    input  logic            i_m_resp_valid,
    output logic            o_m_resp_ready,
    output logic [1:0]      o_s_resp_valid,
    input  logic [1:0]      i_s_resp_ready,
    output logic            o_unexp
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t             r_state;
    logic               r_lock_sel;
    logic               r_last;
    logic               r_owner [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_unexp;

    logic               w_empty;
    logic               w_full;
    logic               w_head;
    logic               w_sel;
    logic               w_grant_ok;
    logic               w_push;
    logic               w_pop;

    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CNT_W'(DEPTH));
    assign w_head     = r_owner[r_rptr];

    // With nothing outstanding a response has no owner, so it is swallowed here.
    assign o_m_resp_ready = w_empty ? i_m_resp_valid : i_s_resp_ready[w_head];
    assign w_pop          = i_m_resp_valid & o_m_resp_ready & ~w_empty;

    // A pop in the same cycle frees a slot, so a full FIFO may still grant.
    assign w_grant_ok = ~w_full | w_pop;

    // Requester selection: held while locked, otherwise round-robin on ties.
    always_comb begin
        w_sel = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_sel = r_lock_sel;
        end else if (&i_s_valid) begin
            w_sel = ~r_last;
        end else begin
            w_sel = i_s_valid[1];
        end
    end

    assign o_m_valid = i_s_valid[w_sel] & w_grant_ok;
    assign o_m_pay   = w_sel ? i_s_pay[2*PW-1:PW] : i_s_pay[PW-1:0];
    assign w_push    = o_m_valid & i_m_ready;
    assign o_unexp   = r_unexp;

    // Ready and response-valid steering toward the selected / owning port.
    always_comb begin
        o_s_ready             = 2'b00;
        o_s_ready[w_sel]      = i_m_ready & w_grant_ok;
        o_s_resp_valid        = 2'b00;
        o_s_resp_valid[w_head] = i_m_resp_valid & ~w_empty;
    end

    // Owner storage: entry content is only meaningful below the count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_owner[r_wptr] <= w_sel;
        end
    end

    // Lock FSM, round-robin history, FIFO pointers/count and the sticky unexpected-response flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_lock_sel <= 1'b0;
            r_last     <= 1'b1;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_unexp    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (o_m_valid && !i_m_ready) begin
                        r_state    <= ST_LOCKED;
                        r_lock_sel <= w_sel;
                    end
                end
                ST_LOCKED: begin
                    if (i_m_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_push) begin
                r_last <= w_sel;
                r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (i_m_resp_valid && w_empty) begin
                r_unexp <= 1'b1;
            end
        end
    end
endmodule

// Top: packs per-port payloads and runs the load and store channels side by side.
module dmem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int LDTAG_W   = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            s_ld_valid,
    output logic [1:0]            s_ld_ready,
    input  logic [2*ADDR_W-1:0]   s_ld_addr,
    input  logic [2*LDTAG_W-1:0]  s_ld_tag,
    output logic [1:0]            s_ld_resp_valid,
    input  logic [1:0]            s_ld_resp_ready,
    output logic [63:0]           s_ld_resp_data,
    output logic [LDTAG_W-1:0]    s_ld_resp_tag,
    output logic                  s_ld_resp_err,
    input  logic [1:0]            s_st_valid,
    output logic [1:0]            s_st_ready,
    input  logic [2*ADDR_W-1:0]   s_st_addr,
    input  logic [127:0]          s_st_wdata,
    input  logic [15:0]           s_st_wstrb,
    output logic [1:0]            s_st_resp_valid,
    input  logic [1:0]            s_st_resp_ready,
    output logic                  m_ld_valid,
    input  logic                  m_ld_ready,
    output logic [ADDR_W-1:0]     m_ld_addr,
    output logic [LDTAG_W-1:0]    m_ld_tag,
    input  logic                  m_ld_resp_valid,
    output logic                  m_ld_resp_ready,
    input  logic [63:0]           m_ld_resp_data,
    input  logic [LDTAG_W-1:0]    m_ld_resp_tag,
    input  logic                  m_ld_resp_err,
    output logic                  m_st_valid,
    input  logic                  m_st_ready,
    output logic [ADDR_W-1:0]     m_st_addr,
    output logic [63:0]           m_st_wdata,
    output logic [7:0]            m_st_wstrb,
    input  logic                  m_st_resp_valid,
    output logic                  m_st_resp_ready,
    output logic                  unexp_resp
);
    localparam int LD_PW = ADDR_W + LDTAG_W;
    localparam int ST_PW = ADDR_W + 64 + 8;

    logic [2*LD_PW-1:0] w_ld_pay;
    logic [LD_PW-1:0]   w_ld_m_pay;
    logic [2*ST_PW-1:0] w_st_pay;
    logic [ST_PW-1:0]   w_st_m_pay;
    logic               w_ld_unexp;
    logic               w_st_unexp;

    assign w_ld_pay = {s_ld_addr[ADDR_W +: ADDR_W], s_ld_tag[LDTAG_W +: LDTAG_W],
                       s_ld_addr[0 +: ADDR_W],      s_ld_tag[0 +: LDTAG_W]};
    assign w_st_pay = {s_st_addr[ADDR_W +: ADDR_W], s_st_wdata[127:64], s_st_wstrb[15:8],
                       s_st_addr[0 +: ADDR_W],      s_st_wdata[63:0],   s_st_wstrb[7:0]};

    dmem_arb_chan #(.PW(LD_PW), .DEPTH(MAX_OUTST)) u_ld (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_s_valid      (s_ld_valid),
        .o_s_ready      (s_ld_ready),
        .i_s_pay        (w_ld_pay),
        .o_m_valid      (m_ld_valid),
        .i_m_ready      (m_ld_ready),
        .o_m_pay        (w_ld_m_pay),
        .i_m_resp_valid (m_ld_resp_valid),
        .o_m_resp_ready (m_ld_resp_ready),
        .o_s_resp_valid (s_ld_resp_valid),
        .i_s_resp_ready (s_ld_resp_ready),
        .o_unexp        (w_ld_unexp)
    );

    dmem_arb_chan #(.PW(ST_PW), .DEPTH(MAX_OUTST)) u_st (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_s_valid      (s_st_valid),
        .o_s_ready      (s_st_ready),
        .i_s_pay        (w_st_pay),
        .o_m_valid      (m_st_valid),
        .i_m_ready      (m_st_ready),
        .o_m_pay        (w_st_m_pay),
        .i_m_resp_valid (m_st_resp_valid),
        .o_m_resp_ready (m_st_resp_ready),
        .o_s_resp_valid (s_st_resp_valid),
        .i_s_resp_ready (s_st_resp_ready),
        .o_unexp        (w_st_unexp)
    );

    assign m_ld_addr  = w_ld_m_pay[LD_PW-1:LDTAG_W];
    assign m_ld_tag   = w_ld_m_pay[LDTAG_W-1:0];
    assign m_st_addr  = w_st_m_pay[ST_PW-1:72];
    assign m_st_wdata = w_st_m_pay[71:8];
    assign m_st_wstrb = w_st_m_pay[7:0];

    // Response payload is shared; only the routed valid bit says who it belongs to.
    assign s_ld_resp_data = m_ld_resp_data;
    assign s_ld_resp_tag  = m_ld_resp_tag;
    assign s_ld_resp_err  = m_ld_resp_err;
    assign unexp_resp     = w_ld_unexp | w_st_unexp;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: load-channel vector table plus hand-written store sequences.
// Inputs change on the falling edge; outputs are sampled 1 ns later, state advances on the rising edge.
// Memory side is modelled only by the ready/response values written into each step.
module tb_dmem_port_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   s_ld_valid, s_ld_ready, s_ld_resp_valid, s_ld_resp_ready;
    logic [63:0]  s_ld_addr;
    logic [7:0]   s_ld_tag;
    logic [63:0]  s_ld_resp_data;
    logic [3:0]   s_ld_resp_tag;
    logic         s_ld_resp_err;
    logic [1:0]   s_st_valid, s_st_ready, s_st_resp_valid, s_st_resp_ready;
    logic [63:0]  s_st_addr;
    logic [127:0] s_st_wdata;
    logic [15:0]  s_st_wstrb;
    logic         m_ld_valid, m_ld_ready, m_ld_resp_valid, m_ld_resp_ready, m_ld_resp_err;
    logic [31:0]  m_ld_addr;
    logic [3:0]   m_ld_tag, m_ld_resp_tag;
    logic [63:0]  m_ld_resp_data;
    logic         m_st_valid, m_st_ready, m_st_resp_valid, m_st_resp_ready;
    logic [31:0]  m_st_addr;
    logic [63:0]  m_st_wdata;
    logic [7:0]   m_st_wstrb;
    logic         unexp_resp;

    int n_pass = 0;
    int n_tot  = 0;

    dmem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .s_ld_valid(s_ld_valid), .s_ld_ready(s_ld_ready), .s_ld_addr(s_ld_addr), .s_ld_tag(s_ld_tag),
        .s_ld_resp_valid(s_ld_resp_valid), .s_ld_resp_ready(s_ld_resp_ready),
        .s_ld_resp_data(s_ld_resp_data), .s_ld_resp_tag(s_ld_resp_tag), .s_ld_resp_err(s_ld_resp_err),
        .s_st_valid(s_st_valid), .s_st_ready(s_st_ready), .s_st_addr(s_st_addr),
        .s_st_wdata(s_st_wdata), .s_st_wstrb(s_st_wstrb),
        .s_st_resp_valid(s_st_resp_valid), .s_st_resp_ready(s_st_resp_ready),
        .m_ld_valid(m_ld_valid), .m_ld_ready(m_ld_ready), .m_ld_addr(m_ld_addr), .m_ld_tag(m_ld_tag),
        .m_ld_resp_valid(m_ld_resp_valid), .m_ld_resp_ready(m_ld_resp_ready),
        .m_ld_resp_data(m_ld_resp_data), .m_ld_resp_tag(m_ld_resp_tag), .m_ld_resp_err(m_ld_resp_err),
        .m_st_valid(m_st_valid), .m_st_ready(m_st_ready), .m_st_addr(m_st_addr),
        .m_st_wdata(m_st_wdata), .m_st_wstrb(m_st_wstrb),
        .m_st_resp_valid(m_st_resp_valid), .m_st_resp_ready(m_st_resp_ready),
        .unexp_resp(unexp_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] vld;   // s_ld_valid
        logic       mrdy;  // m_ld_ready
        logic       rv;    // m_ld_resp_valid
        logic [1:0] rrdy;  // s_ld_resp_ready
        logic       mv;    // expected m_ld_valid
        logic       msel;  // expected port forwarded to memory (when mv)
        logic [1:0] srdy;  // expected s_ld_ready
        logic [1:0] srv;   // expected s_ld_resp_valid
        logic       mrr;   // expected m_ld_resp_ready
    } vec_t;

    vec_t tv [21];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic st_set(input logic [1:0] vld, input logic mrdy, input logic rv, input logic [1:0] rrdy);
        @(negedge clk);
        s_st_valid = vld; m_st_ready = mrdy; m_st_resp_valid = rv; s_st_resp_ready = rrdy;
        #1;
    endtask

    initial begin
        // idle / single load to port 0
        tv[0]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        tv[1]  = '{2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0};
        tv[2]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        tv[3]  = '{2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1};
        // tie: last grant was 0, so port 1 first, then 0; third blocked by full FIFO
        tv[4]  = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0};
        tv[5]  = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0};
        tv[6]  = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0};
        // full FIFO with a pop in the same cycle: grant allowed, response goes to port 1
        tv[7]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1};
        tv[8]  = '{2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1};
        // port 1 response held off for 5 cycles
        for (int k = 9; k <= 13; k++)
            tv[k] = '{2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0};
        tv[14] = '{2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1};
        // lock on port 1, tie during lock must not move to port 0
        tv[15] = '{2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
        tv[16] = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
        tv[17] = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0};
        tv[18] = '{2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1};
        tv[19] = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0};
        tv[20] = '{2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1};

        rst_n = 1'b0;
        s_ld_valid = 2'b00; s_ld_resp_ready = 2'b00; s_st_valid = 2'b00; s_st_resp_ready = 2'b00;
        s_ld_addr  = {32'h0000_0200, 32'h0000_0100};
        s_ld_tag   = {4'h5, 4'h3};
        s_st_addr  = {32'h0000_0400, 32'h0000_0300};
        s_st_wdata = {64'h2222_3333_4444_5555, 64'h1111_AAAA_BBBB_CCCC};
        s_st_wstrb = {8'hF0, 8'h0F};
        m_ld_ready = 1'b0; m_ld_resp_valid = 1'b0; m_ld_resp_data = 64'hDEADBEEF_CAFEF00D;
        m_ld_resp_tag = 4'h3; m_ld_resp_err = 1'b0;
        m_st_ready = 1'b0; m_st_resp_valid = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_ld_valid", 128'(m_ld_valid), 128'(0));
        chk("rst_s_ld_ready", 128'(s_ld_ready), 128'(0));
        chk("rst_m_st_valid", 128'(m_st_valid), 128'(0));
        chk("rst_s_st_ready", 128'(s_st_ready), 128'(0));
        chk("rst_s_ld_resp_valid", 128'(s_ld_resp_valid), 128'(0));
        chk("rst_m_ld_resp_ready", 128'(m_ld_resp_ready), 128'(0));
        chk("rst_m_st_resp_ready", 128'(m_st_resp_ready), 128'(0));
        chk("rst_unexp", 128'(unexp_resp), 128'(0));
        rst_n = 1'b1;

        // load channel vector table
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            s_ld_valid = tv[i].vld; m_ld_ready = tv[i].mrdy;
            m_ld_resp_valid = tv[i].rv; s_ld_resp_ready = tv[i].rrdy;
            #1;
            chk($sformatf("v%0d_m_ld_valid", i), 128'(m_ld_valid), 128'(tv[i].mv));
            chk($sformatf("v%0d_s_ld_ready", i), 128'(s_ld_ready), 128'(tv[i].srdy));
            chk($sformatf("v%0d_s_ld_resp_valid", i), 128'(s_ld_resp_valid), 128'(tv[i].srv));
            chk($sformatf("v%0d_m_ld_resp_ready", i), 128'(m_ld_resp_ready), 128'(tv[i].mrr));
            if (tv[i].mv) begin
                chk($sformatf("v%0d_m_ld_addr", i), 128'(m_ld_addr),
                    tv[i].msel ? 128'(32'h200) : 128'(32'h100));
                chk($sformatf("v%0d_m_ld_tag", i), 128'(m_ld_tag),
                    tv[i].msel ? 128'(4'h5) : 128'(4'h3));
            end
            if (tv[i].srv != 2'b00) begin
                chk($sformatf("v%0d_resp_data", i), 128'(s_ld_resp_data), 128'(64'hDEADBEEF_CAFEF00D));
                chk($sformatf("v%0d_resp_tag", i), 128'(s_ld_resp_tag), 128'(4'h3));
            end
            chk($sformatf("v%0d_unexp", i), 128'(unexp_resp), 128'(0));
        end
        @(negedge clk);
        s_ld_valid = 2'b00; m_ld_ready = 1'b0; m_ld_resp_valid = 1'b0; s_ld_resp_ready = 2'b00;

        // store lock: port 0 stalled 3 cycles, port 1 joins in cycle 2
        st_set(2'b01, 1'b0, 1'b0, 2'b00);
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) begin s_st_valid = 2'b11; #1; end
            chk($sformatf("lock%0d_m_st_valid", c), 128'(m_st_valid), 128'(1));
            chk($sformatf("lock%0d_m_st_addr", c), 128'(m_st_addr), 128'(32'h300));
            chk($sformatf("lock%0d_m_st_wdata", c), 128'(m_st_wdata), 128'(64'h1111_AAAA_BBBB_CCCC));
            chk($sformatf("lock%0d_m_st_wstrb", c), 128'(m_st_wstrb), 128'(8'h0F));
            chk($sformatf("lock%0d_s_st_ready", c), 128'(s_st_ready), 128'(0));
            if (c < 3) st_set(2'b11, 1'b0, 1'b0, 2'b00);
        end
        st_set(2'b11, 1'b1, 1'b0, 2'b00);
        chk("st_hs0_addr", 128'(m_st_addr), 128'(32'h300));
        chk("st_hs0_s_st_ready", 128'(s_st_ready), 128'(2'b01));
        st_set(2'b10, 1'b1, 1'b0, 2'b00);
        chk("st_hs1_addr", 128'(m_st_addr), 128'(32'h400));
        chk("st_hs1_wstrb", 128'(m_st_wstrb), 128'(8'hF0));
        chk("st_hs1_s_st_ready", 128'(s_st_ready), 128'(2'b10));
        // completions routed in grant order 0 then 1
        st_set(2'b00, 1'b0, 1'b1, 2'b11);
        chk("st_resp0_valid", 128'(s_st_resp_valid), 128'(2'b01));
        chk("st_resp0_ready", 128'(m_st_resp_ready), 128'(1));
        st_set(2'b00, 1'b0, 1'b1, 2'b11);
        chk("st_resp1_valid", 128'(s_st_resp_valid), 128'(2'b10));
        // unexpected completion with an empty FIFO
        st_set(2'b00, 1'b0, 1'b1, 2'b00);
        chk("unexp_accept", 128'(m_st_resp_ready), 128'(1));
        chk("unexp_no_route", 128'(s_st_resp_valid), 128'(0));
        chk("unexp_before_edge", 128'(unexp_resp), 128'(0));
        st_set(2'b00, 1'b0, 1'b0, 2'b00);
        chk("unexp_set", 128'(unexp_resp), 128'(1));
        repeat (3) st_set(2'b00, 1'b0, 1'b0, 2'b00);
        chk("unexp_sticky", 128'(unexp_resp), 128'(1));

        // reset with a load outstanding: ownership must be dropped
        @(negedge clk);
        s_ld_valid = 2'b01; m_ld_ready = 1'b1;
        @(negedge clk);
        s_ld_valid = 2'b00; m_ld_ready = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_unexp", 128'(unexp_resp), 128'(0));
        rst_n = 1'b1;
        m_ld_resp_valid = 1'b1; s_ld_resp_ready = 2'b00;
        #1;
        chk("rst2_ld_no_owner", 128'(s_ld_resp_valid), 128'(0));
        chk("rst2_ld_drop", 128'(m_ld_resp_ready), 128'(1));
        @(negedge clk);
        m_ld_resp_valid = 1'b0;
        chk("rst2_unexp_ld", 128'(unexp_resp), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single fixed-latency data memory (one load channel, one store channel, valid/ready with separate response channels) between two requesters: port 0 = LSU, port 1 = debug/DMA loader.
- Load and store channels are arbitrated independently, each with round-robin grant and a request lock.
- A per-channel owner FIFO routes each memory response back to the requester that issued it.
- Sits between the LSU/DMA and the data memory; the memory side is a drop-in for the LSU-facing master.

Parameters:
- ADDR_W, 32, byte address width.
- LDTAG_W, 4, load tag width, passed through unchanged.
- MAX_OUTST, 2, owner-FIFO depth per channel, i.e. max accepted-but-unanswered transactions per channel (power of 2, ≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- s_ld_valid  in  2  per-requester load request valid (bit i = port i).
- s_ld_ready  out  2  per-requester load accept.
- s_ld_addr  in  2*ADDR_W  port i at [i*ADDR_W +: ADDR_W].
- s_ld_tag  in  2*LDTAG_W  per-requester load tag.
- s_ld_resp_valid  out  2  load response valid, routed to owner.
- s_ld_resp_ready  in  2  per-requester response accept.
- s_ld_resp_data  out  64  shared response data, valid only for the bit set in s_ld_resp_valid.
- s_ld_resp_tag  out  LDTAG_W  shared response tag.
- s_ld_resp_err  out  1  shared response error.
- s_st_valid  in  2  per-requester store request valid.
- s_st_ready  out  2  per-requester store accept.
- s_st_addr  in  2*ADDR_W  store address.
- s_st_wdata  in  128  store data, 64 bits per port.
- s_st_wstrb  in  16  byte strobes, 8 bits per port.
- s_st_resp_valid  out  2  store completion, routed to owner.
- s_st_resp_ready  in  2  store completion accept.
- m_ld_valid/m_ld_ready/m_ld_addr/m_ld_tag  out/in/out/out  1/1/ADDR_W/LDTAG_W  memory load request.
- m_ld_resp_valid/m_ld_resp_ready/m_ld_resp_data/m_ld_resp_tag/m_ld_resp_err  in/out/in/in/in  1/1/64/LDTAG_W/1  memory load response.
- m_st_valid/m_st_ready/m_st_addr/m_st_wdata/m_st_wstrb  out/in/out/out/out  1/1/ADDR_W/64/8  memory store request.
- m_st_resp_valid/m_st_resp_ready  in/out  1/1  memory store completion.
- unexp_resp  out  1  sticky flag: a memory response arrived while the owner FIFO was empty.

Behaviour:
- Reset (rst_n low at posedge clk): rr pointers = 0, locks cleared, owner FIFOs empty, unexp_resp = 0. Consequently all m_*_valid, s_*_ready, s_*_resp_valid and m_*_resp_ready are 0 during and after reset until new activity.
- Reset mid-transaction drops all ownership; the memory is reset on the same rst_n, so no stale responses are expected.
- Each channel (LD, ST) has two states:
  - IDLE: select a requester. If one is valid it wins. If both are valid, the winner is the one ≠ last_grant (last_grant resets to 1, so port 0 wins the first tie). No grant is made if the owner FIFO is full.
  - LOCKED: entered when m_*_valid=1 and m_*_ready=0. The selected index is held, so the m_ payload stays stable until the handshake; returns to IDLE on m_*_ready.
- Request forwarding is combinational from the selected port: m_valid = s_valid[sel] & grant_ok; s_ready[sel] = m_ready & grant_ok; s_ready of the other port = 0.
- On handshake (m_valid & m_ready) at posedge: push sel into the owner FIFO and set last_grant = sel. Zero added request latency.
- Response routing: s_resp_valid[head] = m_resp_valid & !fifo_empty; m_resp_ready = s_resp_ready[head]. Pop on m_resp_valid & m_resp_ready. Data/tag/err pass through combinationally.
- Simultaneous push and pop in one cycle is allowed, including when the FIFO is full: the count is unchanged and the grant is permitted, since pop frees the slot that cycle.
- m_resp_valid with an empty FIFO: m_resp_ready = 1 (drop the response), set unexp_resp until reset.
- FIFO pointers are log2(MAX_OUTST)-bit and wrap naturally. The count is a separate log2(MAX_OUTST)+1-bit field.
- Load and store channels are fully independent; there is no cross-channel ordering. Address hazards between ports are the requesters' responsibility.

Test Plan:
- Single LD: port 0 ld addr=0x100 tag=3, memory ready=1, response 2 cycles later with data=0xDEADBEEF_CAFEF00D → s_ld_resp_valid=2'b01, tag=3, data matches; port 1 sees nothing.
- Tie round-robin: both ports hold ld_valid for 4 handshakes → grant order 0,1,0,1; owner FIFO routes each response to the matching port in that order.
- Lock: port 0 st valid with m_st_ready=0 for 3 cycles, port 1 asserts st_valid in cycle 2 → m_st_addr/wdata/wstrb stable on port 0 values; port 1 is granted only after port 0's handshake.
- FIFO full, MAX_OUTST=2: two loads accepted, no responses → s_ld_ready=0 and m_ld_valid=0 for a third request. A response pop in the same cycle as a new request → request accepted that cycle.
- Response backpressure: port 1 holds s_ld_resp_ready=0 for 5 cycles → m_ld_resp_ready=0 throughout; data held by memory; popped on the cycle ready rises.
- Unexpected response: inject m_st_resp_valid with empty FIFO → accepted (m_st_resp_ready=1), no s_st_resp_valid bit set, unexp_resp=1 until rst_n low.
